// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM states and the mode switch encoding.
package cpu_run_ctrl_pkg;

    typedef enum logic [2:0] {
        PAUSE = 3'd0,
        RUN   = 3'd1,
        HALT  = 3'd2,
        DONE  = 3'd3
    } run_state_t;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        STEP  = 2'd1,
        BREAK = 2'd2
    } run_mode_t;

    // Unused switch position; treated exactly like FREE.
    localparam logic [1:0] MODE_RESERVED = 2'd3;

    function automatic logic mode_runs_freely(input logic [1:0] m);
        return (m == FREE) || (m == BREAK) || (m == MODE_RESERVED);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn.sv
// Button conditioner: 2-flop synchroniser, stability counter, one-cycle pulse
// on each accepted press (debounced 1 -> 0 transition).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic CLK_50,
    input  logic resetN,
    input  logic btnN,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            sync_q  <= 2'b11;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btnN};
            level_d <= level;
            press   <= level_d & ~level;
            // Any sample agreeing with the current level restarts the stability window.
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_q[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the CPU clock enable: free-run, single-step or run-to-breakpoint,
// with a saturating executed-cycle counter and stop-PC capture.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int PC_WIDTH        = 10,
    parameter int CNT_WIDTH       = 32,
    parameter int NUM_BP          = 4,
    parameter int FINAL_PC        = 2**PC_WIDTH - 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                       CLK_50,
    input  logic                       resetN,
    input  logic [PC_WIDTH-1:0]        pc,
    input  logic [1:0]                 mode,
    input  logic                       step_btnN,
    input  logic                       run_btnN,
    input  logic [NUM_BP*PC_WIDTH-1:0] bp_addr,
    input  logic [NUM_BP-1:0]          bp_en,
    output logic                       cpu_ena,
    output logic                       finished,
    output logic                       halted,
    output logic [PC_WIDTH-1:0]        halted_pc,
    output logic [CNT_WIDTH-1:0]       cycle_count,
    output logic [2:0]                 state_o
);

    localparam logic [PC_WIDTH-1:0] FINAL_PC_V = PC_WIDTH'(FINAL_PC);

    run_state_t          state, state_nxt;
    logic                ena_nxt, fin_nxt, hlt_nxt, skip_nxt;
    logic                skip_bp;
    logic [PC_WIDTH-1:0] hpc_nxt;
    logic                step_press, run_press;
    logic [NUM_BP-1:0]   bp_hit;
    logic                bp_match;
    logic                free_mode;
    logic                final_hit, bp_stop;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .CLK_50 (CLK_50),
        .resetN (resetN),
        .btnN   (step_btnN),
        .press  (step_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
        .CLK_50 (CLK_50),
        .resetN (resetN),
        .btnN   (run_btnN),
        .press  (run_press)
    );

    for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
        assign bp_hit[i] = bp_en[i] && (bp_addr[i*PC_WIDTH +: PC_WIDTH] == pc);
    end
    assign bp_match = |bp_hit;

    assign free_mode = mode_runs_freely(mode);
    // Stop decisions are taken only on exec cycles; FINAL_PC outranks breakpoints.
    assign final_hit = cpu_ena && (pc == FINAL_PC_V);
    assign bp_stop   = cpu_ena && (mode == BREAK) && bp_match && !skip_bp;

    always_comb begin
        state_nxt = state;
        ena_nxt   = 1'b0;
        fin_nxt   = finished;
        hlt_nxt   = halted;
        hpc_nxt   = halted_pc;
        skip_nxt  = skip_bp;
        if (cpu_ena)
            skip_nxt = 1'b0;
        if (final_hit) begin
            state_nxt = DONE;
            fin_nxt   = 1'b1;
            hpc_nxt   = pc;
        end else if (bp_stop) begin
            state_nxt = HALT;
            hlt_nxt   = 1'b1;
            hpc_nxt   = pc;
        end else begin
            case (state)
                PAUSE: begin
                    if (free_mode) begin
                        state_nxt = RUN;
                        ena_nxt   = 1'b1;
                    end else if (step_press) begin
                        ena_nxt = 1'b1;
                    end
                end
                RUN: begin
                    if (free_mode)
                        ena_nxt = 1'b1;
                    else
                        state_nxt = PAUSE;
                end
                HALT: begin
                    if (run_press) begin
                        hlt_nxt  = 1'b0;
                        skip_nxt = 1'b1;
                        if (free_mode) begin
                            state_nxt = RUN;
                            ena_nxt   = 1'b1;
                        end else begin
                            state_nxt = PAUSE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state     <= PAUSE;
            cpu_ena   <= 1'b0;
            finished  <= 1'b0;
            halted    <= 1'b0;
            halted_pc <= '0;
            skip_bp   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cpu_ena   <= ena_nxt;
            finished  <= fin_nxt;
            halted    <= hlt_nxt;
            halted_pc <= hpc_nxt;
            skip_bp   <= skip_nxt;
        end
    end

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN)
            cycle_count <= '0;
        else if (cpu_ena && !(&cycle_count))
            cycle_count <= cycle_count + CNT_WIDTH'(1);
    end

    assign state_o = state;

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Parametrised run controller that generalises the CPU's single "finished" clock-enable gate into a mode-selectable execution engine: free-run to a final PC, single-step on a button, or run to one of several hardware breakpoints. It sits between the board buttons/switches and the CPU clock-control enable. It counts executed CPU cycles with a configurable-width saturating counter, and captures the PC at which execution stopped.

## Interface
Parameters:
- PC_WIDTH, 10, width of program counter
- CNT_WIDTH, 32, width of executed-cycle counter
- NUM_BP, 4, number of breakpoint channels (1..8)
- FINAL_PC, 2**PC_WIDTH-1, PC value that terminates execution
- DEBOUNCE_CYCLES, 50000, stable cycles needed to accept a button level (the bench uses 4)

Ports:
- CLK_50  input  1  the single clock; the only clock in the block
- resetN  input  1  asynchronous active-low reset
- pc  input  PC_WIDTH  current CPU instruction address
- mode  input  2  0=FREE, 1=STEP, 2=BREAK, 3=reserved (behaves as FREE)
- step_btnN  input  1  raw active-low step button, asynchronous to CLK_50
- run_btnN  input  1  raw active-low resume button, asynchronous to CLK_50
- bp_addr  input  NUM_BP*PC_WIDTH  breakpoint addresses; channel i occupies bits [i*PC_WIDTH +: PC_WIDTH]
- bp_en  input  NUM_BP  per-channel breakpoint enable
- cpu_ena  output  1  registered enable for the CPU clock control
- finished  output  1  high once FINAL_PC has been executed
- halted  output  1  high while in HALT
- halted_pc  output  PC_WIDTH  PC captured at the last stop
- cycle_count  output  CNT_WIDTH  number of cycles with cpu_ena=1, saturating
- state_o  output  3  current state encoding, for the LEDs

## Operation
- States: PAUSE, RUN, HALT, DONE.
- Reset values: state=PAUSE, cpu_ena=0, finished=0, halted=0, halted_pc=0, cycle_count=0, skip_bp=0.
- "Exec cycle" = a cycle in which the registered cpu_ena is 1.
- PAUSE:
  - If mode≠STEP, go to RUN next cycle.
  - If mode=STEP and a step press event occurs, cpu_ena=1 for exactly one cycle, then return to PAUSE.
- RUN:
  - cpu_ena=1.
  - If mode changes to STEP, go to PAUSE next cycle.
- Termination: an exec cycle with pc==FINAL_PC has priority over any breakpoint.
  - Next state is DONE; cpu_ena=0, finished=1, halted_pc=pc.
  - DONE is left only by reset.
- Breakpoint (mode=BREAK only): an exec cycle with pc==bp_addr[i] and bp_en[i] for any i, and skip_bp=0:
  - Next state is HALT; cpu_ena=0, halted=1, halted_pc=pc.
- HALT:
  - A run press event sets skip_bp=1 and moves to RUN (mode BREAK/FREE) or PAUSE (mode STEP); halted clears.
  - skip_bp suppresses breakpoint matching for the first exec cycle only, then clears.
- Step presses in RUN/HALT/DONE, and run presses outside HALT, are ignored.
- Press event: a debounced level change from 1 to 0. One event per physical press.
- Debounce: 2-flop synchroniser, then a counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
- Debounce reset: debounced level=1 (released), counter=0.
- cycle_count increments on every exec cycle and saturates at all-ones. It is not cleared by DONE/HALT.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). Behaviour after release is identical to power-up.

## Timing
- All outputs are registered; no combinational path from input to output.
- Stop latency: the exec cycle that sees the stop PC is the last exec cycle. cpu_ena is 0 in the following cycle. cycle_count includes the stop cycle.
- PAUSE→RUN: cpu_ena rises 1 cycle after reset release when mode=FREE.
- Step: press event at cycle t gives cpu_ena=1 in cycle t+1 only.
- Button to event latency: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Simultaneous FINAL_PC and breakpoint match: DONE wins, halted stays 0.

## Structure
- Package cpu_run_ctrl_pkg holds:
  - state enum run_state_t (PAUSE=0, RUN=1, HALT=2, DONE=3)
  - mode enum run_mode_t (FREE, STEP, BREAK)
  - MODE_RESERVED constant
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports CLK_50, resetN, btnN, press) is instantiated twice, once for step_btnN and once for run_btnN.
- Breakpoint compare is a generate loop OR-reduced into a single match bit.

## Test plan
- FREE, FINAL_PC=5, pc follows a cycle index 0..7 -> cpu_ena falls after pc=5; finished=1, halted_pc=5, cycle_count=6.
- BREAK, bp_en=4'b0010, bp_addr[1]=3 -> HALT after pc=3, halted_pc=3, cycle_count=4. A run press -> resumes; no re-halt at pc=3; finishes at FINAL_PC.
- STEP, DEBOUNCE_CYCLES=4, three clean presses, plus one press with 2-cycle glitches -> exactly three 1-cycle cpu_ena pulses; glitch ignored; cycle_count=3.
- CNT_WIDTH=4, FREE, FINAL_PC never reached for 20 cycles -> cycle_count holds 4'hF.
- Breakpoint at FINAL_PC in BREAK mode -> finished=1, halted=0.
- resetN pulsed low while in RUN with cycle_count=9 -> all outputs reset values the same cycle; cpu_ena=1 again one cycle after release.
